// File: rtl/fib_pkg.sv
// Shared types and ALU opcodes for the Fibonacci sequencer.
// The opcode constants are shared with the external ALU.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } fib_state_t;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0011;

endpackage

// File: rtl/fib_alu_sequencer.sv
// Drives an external combinational ALU to compute F(n), one add per clock,
// and returns the result on a valid/ready port.
// Ports: clk, rst (sync, active-high), start/n request, busy,
//        alu_mode/alu_a/alu_b to the ALU, alu_s from the ALU,
//        res/res_valid/res_ready result handshake,
//        ovf (only when FIB_OVF_EN is defined; result saturates).
module fib_alu_sequencer
    import fib_pkg::*;
#(
    parameter int W  = 8,
    parameter int NW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] n,
    output logic          busy,
    output logic [3:0]    alu_mode,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    input  logic [W-1:0]  alu_s,
    output logic [W-1:0]  res,
    output logic          res_valid,
`ifdef FIB_OVF_EN
    output logic          ovf,
`endif
    input  logic          res_ready
);

    fib_state_t    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  res_q, res_d;
    logic          res_valid_q, res_valid_d;
`ifdef FIB_OVF_EN
    logic          a_ovf_q, a_ovf_d;
    logic          b_ovf_q, b_ovf_d;
    logic          ovf_q, ovf_d;
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        alu_mode    = ALU_NOP;
`ifdef FIB_OVF_EN
        a_ovf_d     = a_ovf_q;
        b_ovf_d     = b_ovf_q;
        ovf_d       = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = n;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                a_d     = '0;
                b_d     = W'(1);
`ifdef FIB_OVF_EN
                a_ovf_d = 1'b0;
                b_ovf_d = 1'b0;
`endif
                state_d = STEP;
            end
            STEP: begin
                if (cnt_q != '0) begin
                    alu_mode = ALU_ADD;
                    a_d      = b_q;
                    b_d      = alu_s;
                    cnt_d    = cnt_q - NW'(1);
`ifdef FIB_OVF_EN
                    // a sum smaller than an addend means the add carried out
                    b_ovf_d  = b_ovf_q | a_ovf_q | (alu_s < alu_b);
                    a_ovf_d  = b_ovf_q;
`endif
                end else begin
`ifdef FIB_OVF_EN
                    res_d    = a_ovf_q ? {W{1'b1}} : a_q;
                    ovf_d    = a_ovf_q;
`else
                    res_d    = a_q;
`endif
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
`ifdef FIB_OVF_EN
                    ovf_d       = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
`ifdef FIB_OVF_EN
            a_ovf_q     <= 1'b0;
            b_ovf_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
`ifdef FIB_OVF_EN
            a_ovf_q     <= a_ovf_d;
            b_ovf_q     <= b_ovf_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign res       = res_q;
    assign res_valid = res_valid_q;
`ifdef FIB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_fib_alu_sequencer.sv
// Self-checking bench for fib_alu_sequencer with a behavioural ALU
// and a true-arithmetic Fibonacci reference model.
module tb_fib_alu_sequencer;
    import fib_pkg::*;

    localparam int W  = 8;
    localparam int NW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NW-1:0] n;
    logic          busy;
    logic [3:0]    alu_mode;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [W-1:0]  alu_s;
    logic [W-1:0]  res;
    logic          res_valid;
    logic          res_ready;
`ifdef FIB_OVF_EN
    logic          ovf;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // ALU: add under ALU_ADD, junk otherwise (sequencer must ignore it)
    assign alu_s = (alu_mode == ALU_ADD) ? W'(alu_a + alu_b)
                                         : (alu_a ^ 8'hA5);

    fib_alu_sequencer #(.W(W), .NW(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n         (n),
        .busy      (busy),
        .alu_mode  (alu_mode),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .res       (res),
        .res_valid (res_valid),
`ifdef FIB_OVF_EN
        .ovf       (ovf),
`endif
        .res_ready (res_ready)
    );

    // Reference: exact Fibonacci, then wrap or saturate
    function automatic logic [W-1:0] fib_ref(input int k, output bit o);
        longint fa = 0;
        longint fb = 1;
        longint t;
        for (int i = 0; i < k; i++) begin
            t  = fa + fb;
            fa = fb;
            fb = t;
        end
        o = (fa > 255);
`ifdef FIB_OVF_EN
        if (o) return 8'hFF;
`endif
        return fa[W-1:0];
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; n = '0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res !== '0 ||
            alu_mode !== ALU_NOP) begin
            failures++;
            $display("FAIL reset: busy=%b valid=%b res=%h mode=%h want 0 0 00 %h",
                     busy, res_valid, res, alu_mode, ALU_NOP);
        end
`ifdef FIB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One request. hold: cycles res_ready stays low after valid.
    // inj: edge index at which a stray start is driven (-1 none).
    // inj_done: drive start together with the handshake.
    task automatic run_fib(input int nn, input int hold, input int inj,
                           input bit inj_done, input string tag);
        logic [W-1:0] exp;
        bit exp_o;
        int edges = 0;
        int adds  = 0;
        bit busy_ok = 1'b1;
        exp = fib_ref(nn, exp_o);
        res_ready = (hold == 0);
        start = 1'b1;
        n = NW'(nn);
        @(negedge clk);
        start = 1'b0;
        while (!res_valid && edges < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (alu_mode === ALU_ADD) adds++;
            start = (edges == inj);
            n = NW'($urandom_range(0, 31));
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        checks++;
        if (edges != nn + 2) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", tag, edges, nn + 2);
        end
        checks++;
        if (res !== exp) begin
            failures++;
            $display("FAIL %s res: got %h want %h", tag, res, exp);
        end
        checks++;
        if (!busy_ok || adds != nn) begin
            failures++;
            $display("FAIL %s busy/adds: busy_ok=%0b adds=%0d want 1 %0d",
                     tag, busy_ok, adds, nn);
        end
`ifdef FIB_OVF_EN
        checks++;
        if (ovf !== exp_o) begin
            failures++;
            $display("FAIL %s ovf: got %b want %b", tag, ovf, exp_o);
        end
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res !== exp || busy !== 1'b1) begin
                failures++;
                $display("FAIL %s hold%0d: valid=%b res=%h want 1 %h",
                         tag, i, res_valid, res, exp);
            end
        end
        res_ready = 1'b1;
        if (inj_done) begin
            start = 1'b1;
            n = 5'd3;
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s handshake: valid=%b busy=%b want 0 0",
                     tag, res_valid, busy);
        end
`ifdef FIB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL %s ovf_clear: got %b want 0", tag, ovf);
        end
`endif
        if (inj_done) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL %s start_in_done: busy=%b want 0", tag, busy);
            end
        end
    endtask

    task automatic test_directed();
        run_fib(0, 0, -1, 1'b0, "n0");
        run_fib(1, 0, -1, 1'b0, "n1");
        run_fib(10, 0, -1, 1'b0, "n10");
        run_fib(13, 0, -1, 1'b0, "n13");
        run_fib(14, 0, -1, 1'b0, "n14");
        run_fib(31, 0, -1, 1'b0, "n31");
    endtask

    task automatic test_backpressure();
        run_fib(5, 20, -1, 1'b0, "bp5");
    endtask

    task automatic test_busy_start();
        run_fib(10, 0, 0, 1'b0, "inj_load");
        run_fib(10, 0, 4, 1'b0, "inj_step");
        run_fib(10, 0, 11, 1'b0, "inj_last");
        run_fib(4, 2, 7, 1'b1, "inj_done");
    endtask

    task automatic test_back_to_back();
        run_fib(2, 0, -1, 1'b1, "b2b_a");
        run_fib(3, 0, -1, 1'b0, "b2b_b");
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        n = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res !== '0 ||
            alu_mode !== ALU_NOP) begin
            failures++;
            $display("FAIL mid_reset: busy=%b valid=%b res=%h mode=%h",
                     busy, res_valid, res, alu_mode);
        end
        run_fib(6, 0, -1, 1'b0, "after_rst");
        checks++;
        if (res !== 8'd8) begin
            failures++;
            $display("FAIL after_rst_res: got %h want 08", res);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_fib(int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 3)),
                    -1, 1'b0, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_busy_start();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
